// File: rtl/mul_pkg.sv
// mul_pkg: shared constants and types for the multiplier issue controller.
//   XLEN        - operand/result width
//   MUL_LAT     - default multiplier pipeline latency
//   RSP_ID_W    - id field width carried in a response entry (covers up to 256 requesters)
//   rsp_entry_t - response FIFO entry {id, result}
//   word_adjust - sign-extends product[31:0] for word ops
package mul_pkg;

  localparam int XLEN     = 64;
  localparam int MUL_LAT  = 3;
  localparam int RSP_ID_W = 8;

  typedef struct packed {
    logic [RSP_ID_W-1:0] id;
    logic [XLEN-1:0]     result;
  } rsp_entry_t;

  // Word ops return the sign-extended low half; the low 32 bits of the
  // product do not depend on the operands' upper bits, so no operand fixup.
  function automatic logic [XLEN-1:0] word_adjust(input logic [XLEN-1:0] p,
                                                  input logic            word);
    logic [XLEN-1:0] r;
    if (word) begin
      r = {{32{p[31]}}, p[31:0]};
    end else begin
      r = p;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_rsp_fifo.sv
// mul_rsp_fifo: synchronous FIFO with registered storage and count output.
//   clk, rstn  - clock, asynchronous active-low reset (empties the FIFO)
//   push_i     - write data_i (ignored when full; the caller guarantees space)
//   data_i     - write data
//   pop_i      - remove head entry when valid_o
//   valid_o    - FIFO not empty
//   data_o     - head entry, zero while empty
//   count_o    - number of stored entries
module mul_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 72
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic                         valid_o,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PW'(DEPTH-1)) begin
      n = '0;
    end else begin
      n = p + 1'b1;
    end
    return n;
  endfunction

  assign do_push_s = push_i && (count_q != CW'(DEPTH));
  assign do_pop_s  = pop_i && (count_q != '0);

  // Pointer and count next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State and storage registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/mul_issue_arb.sv
// mul_issue_arb: round-robin issue controller sharing one fixed-latency,
// non-stallable multiplier between NREQ requesters. Results land in a
// response FIFO; a credit check (FIFO count + in-flight < FIFO_DEPTH)
// guarantees every issued product has a slot, so the pipe never stalls.
//   clk, rstn                 - clock, asynchronous active-low reset
//   req_valid_i/req_ready_o   - per-requester handshake (ready one-hot or zero)
//   req_op1_i/req_op2_i       - operands, requester i at [64i+63:64i]
//   req_word_i                - word op: result = sext(product[31:0])
//   mul_op1_o/mul_op2_o       - operands to multiplier (0 when not issuing)
//   mul_result_i              - multiplier result, MUL_LAT cycles after issue
//   rsp_valid_o/rsp_ready_i   - response handshake
//   rsp_id_o/rsp_result_o     - originating requester and product
module mul_issue_arb
  import mul_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int MUL_LAT    = mul_pkg::MUL_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [NREQ-1:0]                        req_valid_i,
  output logic [NREQ-1:0]                        req_ready_o,
  input  logic [NREQ*XLEN-1:0]                   req_op1_i,
  input  logic [NREQ*XLEN-1:0]                   req_op2_i,
  input  logic [NREQ-1:0]                        req_word_i,
  output logic [XLEN-1:0]                        mul_op1_o,
  output logic [XLEN-1:0]                        mul_op2_o,
  input  logic [XLEN-1:0]                        mul_result_i,
  output logic                                   rsp_valid_o,
  input  logic                                   rsp_ready_i,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id_o,
  output logic [XLEN-1:0]                        rsp_result_o
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH+1);

  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW-1:0] win_s;
  logic           found_s;
  logic           allowed_s;
  logic           issue_s;

  logic           trk_valid_q [MUL_LAT];
  logic [IDW-1:0] trk_id_q    [MUL_LAT];
  logic           trk_word_q  [MUL_LAT];

  rsp_entry_t     push_entry_s;
  rsp_entry_t     rsp_entry_s;
  logic           fifo_valid_s;
  logic [CW-1:0]  fifo_count_s;
  logic           unused_id_s;

  // Credit check: everything in flight already owns a FIFO slot.
  always_comb begin
    int occ;
    occ = int'(fifo_count_s);
    for (int k = 0; k < MUL_LAT; k++) begin
      occ = occ + int'(trk_valid_q[k]);
    end
    allowed_s = (occ < FIFO_DEPTH);
  end

  // Round-robin search starting at rr_q, wrapping.
  always_comb begin
    int idx;
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!found_s && req_valid_i[idx]) begin
        found_s = 1'b1;
        win_s   = IDW'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign issue_s = found_s && allowed_s;

  // Grant, multiplier operands and pointer advance.
  always_comb begin
    req_ready_o = '0;
    mul_op1_o   = '0;
    mul_op2_o   = '0;
    rr_d        = rr_q;
    if (issue_s) begin
      req_ready_o[win_s] = 1'b1;
      mul_op1_o = req_op1_i[int'(win_s)*XLEN +: XLEN];
      mul_op2_o = req_op2_i[int'(win_s)*XLEN +: XLEN];
      if (win_s == IDW'(NREQ-1)) begin
        rr_d = '0;
      end else begin
        rr_d = win_s + 1'b1;
      end
    end else begin
      rr_d = rr_q;
    end
  end

  // Round-robin pointer and tracking shift register; stage MUL_LAT-1 lines
  // up with the cycle mul_result_i carries that issue's product.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        trk_valid_q[k] <= 1'b0;
        trk_id_q[k]    <= '0;
        trk_word_q[k]  <= 1'b0;
      end
    end else begin
      rr_q           <= rr_d;
      trk_valid_q[0] <= issue_s;
      trk_id_q[0]    <= win_s;
      trk_word_q[0]  <= req_word_i[win_s];
      for (int k = 1; k < MUL_LAT; k++) begin
        trk_valid_q[k] <= trk_valid_q[k-1];
        trk_id_q[k]    <= trk_id_q[k-1];
        trk_word_q[k]  <= trk_word_q[k-1];
      end
    end
  end

  // Response entry built from the product leaving the multiplier.
  always_comb begin
    push_entry_s                = '0;
    push_entry_s.id[IDW-1:0]    = trk_id_q[MUL_LAT-1];
    push_entry_s.result         = word_adjust(mul_result_i, trk_word_q[MUL_LAT-1]);
  end

  mul_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(rsp_entry_t))
  ) u_rsp_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (trk_valid_q[MUL_LAT-1]),
    .data_i  (push_entry_s),
    .pop_i   (rsp_ready_i),
    .valid_o (fifo_valid_s),
    .data_o  (rsp_entry_s),
    .count_o (fifo_count_s)
  );

  assign rsp_valid_o  = fifo_valid_s;
  assign rsp_id_o     = rsp_entry_s.id[IDW-1:0];
  assign rsp_result_o = rsp_entry_s.result;
  assign unused_id_s  = ^rsp_entry_s.id;

endmodule

// File: tb/tb_mul_issue_arb.sv
module tb_mul_issue_arb;

  localparam int NREQ  = 2;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rstn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready_o;
  logic [NREQ*64-1:0] req_op1;
  logic [NREQ*64-1:0] req_op2;
  logic [NREQ-1:0]    req_word;
  logic [63:0]        mul_op1_o, mul_op2_o, mul_result_i;
  logic               rsp_valid_o;
  logic               rsp_ready;
  logic [0:0]         rsp_id_o;
  logic [63:0]        rsp_result_o;

  always #5 clk = ~clk;

  mul_issue_arb #(.NREQ(NREQ), .MUL_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_op1_i    (req_op1),
    .req_op2_i    (req_op2),
    .req_word_i   (req_word),
    .mul_op1_o    (mul_op1_o),
    .mul_op2_o    (mul_op2_o),
    .mul_result_i (mul_result_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id_o),
    .rsp_result_o (rsp_result_o)
  );

  // Attached multiplier: LAT-stage pipeline, low 64 bits of the product.
  logic [63:0] mp [LAT];
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LAT; i++) mp[i] <= '0;
    end else begin
      mp[0] <= mul_op1_o * mul_op2_o;
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign mul_result_i = mp[LAT-1];

  // Reference model: issued-but-not-popped responses in issue order, each
  // visible from cycle due onward; its size is the occupancy.
  typedef struct {
    int          id;
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t q[$];
  int   rr_m;
  int   cyc;
  int   checks;
  int   errors;

  logic [NREQ-1:0] obs_ready;
  logic            obs_valid;
  logic [63:0]     obs_result;
  int              obs_id;
  logic            obs_pop;

  function automatic logic [63:0] ref_product(input logic [63:0] a,
                                              input logic [63:0] b,
                                              input logic        w);
    logic [63:0] p;
    p = a * b;
    if (w) return {{32{p[31]}}, p[31:0]};
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
  endtask

  // One clock: compare all outputs against the model mid-cycle, then
  // advance the model and return just after the next rising edge.
  task automatic tick();
    int          win;
    int          idx;
    logic        exp_issue;
    logic        exp_valid;
    logic [63:0] exp_ready;
    logic [63:0] e1, e2;
    exp_t        e;
    @(negedge clk);
    win = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (rr_m + k) % NREQ;
      if (win < 0 && req_valid[idx]) win = idx;
    end
    exp_issue = (win >= 0) && (q.size() < DEPTH);
    exp_ready = exp_issue ? (64'd1 << win) : 64'd0;
    e1 = exp_issue ? req_op1[win*64 +: 64] : 64'd0;
    e2 = exp_issue ? req_op2[win*64 +: 64] : 64'd0;
    exp_valid = (q.size() > 0) && (q[0].due <= cyc);
    check("req_ready", {62'd0, req_ready_o}, exp_ready);
    check("mul_op1", mul_op1_o, e1);
    check("mul_op2", mul_op2_o, e2);
    check("rsp_valid", {63'd0, rsp_valid_o}, {63'd0, exp_valid});
    if (exp_valid) begin
      check("rsp_id", {63'd0, rsp_id_o}, 64'(q[0].id));
      check("rsp_result", rsp_result_o, q[0].res);
    end
    obs_ready  = req_ready_o;
    obs_valid  = rsp_valid_o;
    obs_result = rsp_result_o;
    obs_id     = int'(rsp_id_o);
    obs_pop    = rsp_valid_o & rsp_ready;
    if (exp_issue) begin
      e.id  = win;
      e.res = ref_product(req_op1[win*64 +: 64], req_op2[win*64 +: 64], req_word[win]);
      e.due = cyc + LAT + 1;
      q.push_back(e);
      rr_m = (win + 1) % NREQ;
    end
    if (exp_valid && rsp_ready) void'(q.pop_front());
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rstn = 1'b0;
    #1;
    check("rst_rsp_valid", {63'd0, rsp_valid_o}, 64'd0);
    check("rst_rsp_id", {63'd0, rsp_id_o}, 64'd0);
    check("rst_rsp_result", rsp_result_o, 64'd0);
    check("rst_req_ready", {62'd0, req_ready_o}, 64'd0);
    check("rst_mul_op1", mul_op1_o, 64'd0);
    q.delete();
    rr_m = 0;
    @(posedge clk);
    @(posedge clk);
    cyc += 2;
    #1;
    rstn = 1'b1;
  endtask

  // Single issue from requester 0, response expected exactly LAT+1 later.
  task automatic single(input logic [63:0] a, input logic [63:0] b, input logic w,
                        input logic [63:0] exp, input string tag);
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    req_op1[63:0] = a;
    req_op2[63:0] = b;
    req_word[0] = w;
    tick();
    check({tag, "_issue"}, {62'd0, obs_ready}, 64'd1);
    req_valid = '0;
    for (int i = 0; i < LAT; i++) tick();
    check({tag, "_early"}, {63'd0, obs_valid}, 64'd0);
    tick();
    check({tag, "_valid"}, {63'd0, obs_valid}, 64'd1);
    check({tag, "_id"}, 64'(obs_id), 64'd0);
    check({tag, "_result"}, obs_result, exp);
  endtask

  int grants[$];
  int rids[$];
  int acc;

  initial begin
    checks = 0; errors = 0; cyc = 0; rr_m = 0;
    req_valid = '0; req_op1 = '0; req_op2 = '0; req_word = '0; rsp_ready = 1'b1;
    rstn = 1'b1;
    #2;
    do_reset();

    single(64'd3, 64'd5, 1'b0, 64'h0000_0000_0000_000F, "t_basic");
    single(64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFD6, "t_signed");
    single(64'h0000_0000_7FFF_FFFF, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, "t_word");

    // Both requesters continuously valid: grants alternate, responses in order.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int i = 0; i < 40 && grants.size() < 8; i++) begin
      req_op1 = {$urandom, $urandom, $urandom, $urandom};
      req_op2 = {$urandom, $urandom, $urandom, $urandom};
      req_word = 2'($urandom_range(0, 3));
      tick();
      if (obs_ready != '0) grants.push_back(obs_ready[1] ? 1 : 0);
      if (obs_pop) rids.push_back(obs_id);
    end
    req_valid = '0;
    for (int i = 0; i < 40 && rids.size() < 8; i++) begin
      tick();
      if (obs_pop) rids.push_back(obs_id);
    end
    check("alt_grant_count", 64'(grants.size()), 64'd8);
    check("alt_rsp_count", 64'(rids.size()), 64'd8);
    for (int i = 0; i < grants.size(); i++) check("alt_grant", 64'(grants[i]), 64'(i % 2));
    for (int i = 0; i < rids.size(); i++) check("alt_rsp_id", 64'(rids[i]), 64'(i % 2));

    // Backpressure: credits limit acceptance to the FIFO depth.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_op1[63:0] = 64'(i + 10);
      req_op2[63:0] = 64'(i + 3);
      tick();
      if (obs_ready[0]) acc++;
    end
    check("bp_accepted", 64'(acc), 64'd4);
    check("bp_ready_low", {62'd0, obs_ready}, 64'd0);
    rsp_ready = 1'b1;
    tick();
    check("bp_first_pop", {63'd0, obs_pop}, 64'd1);
    check("bp_no_issue_on_pop", {62'd0, obs_ready}, 64'd0);
    tick();
    check("bp_resume", {62'd0, obs_ready}, 64'd1);
    req_valid = '0;
    for (int i = 0; i < 10; i++) tick();

    // Reset while products are in flight and one is about to surface.
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    req_op1[63:0] = 64'd7; req_op2[63:0] = 64'd9; req_word = '0;
    tick();
    req_op1[63:0] = 64'd11;
    tick();
    req_valid = '0;
    tick();
    tick();
    check("mid_valid_before_rst", {63'd0, rsp_valid_o}, 64'd1);
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    single(64'd12, 64'd12, 1'b0, 64'd144, "t_after_rst");

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_op1   = {$urandom, $urandom, $urandom, $urandom};
      req_op2   = {$urandom, $urandom, $urandom, $urandom};
      req_word  = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (i == 200) do_reset();
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
